// File: rtl/imem_responder_pkg.sv
// imem_pkg: shared FSM state type and word constants for the instruction-memory responder.
package imem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
  localparam logic [31:0] NOP_WORD = 32'h0;
  localparam int unsigned WORD_BYTES = 4;
endpackage

// File: rtl/imem_wait_counter.sv
// imem_wait_counter: loadable down-counter that flags done when it reaches zero.
module imem_wait_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         en_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) cnt_q <= '0;
    else if (load_i) cnt_q <= value_i;
    else if (en_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  assign done_o = cnt_q == '0;
endmodule

// File: rtl/imem_responder.sv
// imem_responder: handshaked instruction-fetch responder with wait states and a preload port.
// Define IMEM_RESPONDER_ERR_CHECK_EN to flag misaligned/out-of-range fetches and drop out-of-range preloads.
import imem_pkg::*;
module imem_responder #(
  parameter int DEPTH_WORDS = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic        err_o,
  input  logic        ready_i,
  input  logic        load_en_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_data_i
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * WORD_BYTES);
  localparam logic [3:0] WLOAD = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
  state_t state_q, state_d;
  logic [31:0] addr_q, rd_addr, instr_q, instr_d;
  logic err_q, err_d, rd_err, wr_ok, enter_resp, cnt_done, unused_bits;
  logic [31:0] mem_q [DEPTH_WORDS];
  imem_wait_counter #(.W(4)) u_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (state_q == IDLE && req_i && WAIT_CYCLES > 0),
    .value_i(WLOAD),
    .en_i   (state_q == WAIT),
    .done_o (cnt_done)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = req_i ? (WAIT_CYCLES > 0 ? WAIT : RESP) : IDLE;
      WAIT:    state_d = cnt_done ? RESP : WAIT;
      RESP:    state_d = ready_i ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // With zero wait states the read happens on the accepting edge, so use the live address.
  assign rd_addr = (state_q == IDLE) ? addr_i : addr_q;
`ifdef IMEM_RESPONDER_ERR_CHECK_EN
  assign rd_err = (rd_addr[1:0] != 2'b00) || (rd_addr >= LIMIT);
  assign wr_ok  = load_addr_i < LIMIT;
`else
  assign rd_err = 1'b0;
  assign wr_ok  = 1'b1;
`endif
  assign unused_bits = ^{rd_addr, load_addr_i};
  assign enter_resp = (state_d == RESP) && (state_q != RESP);
  assign instr_d = enter_resp ? (rd_err ? NOP_WORD : mem_q[rd_addr[2 +: AW]]) : instr_q;
  assign err_d = enter_resp ? rd_err : err_q;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      instr_q <= NOP_WORD;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= (state_q == IDLE && req_i) ? addr_i : addr_q;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  // Storage is not reset; a write on the read edge lands after the registered read.
  always_ff @(posedge clk_i)
    if (load_en_i && wr_ok) mem_q[load_addr_i[2 +: AW]] <= load_data_i;
  assign ready_o = state_q == IDLE;
  assign valid_o = state_q == RESP;
  assign instr_o = instr_q;
  assign err_o   = err_q;
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: randomized and directed checks of imem_responder against a word-array model.
module tb_imem_responder;
  localparam int DEPTH = 32;
  localparam int WC = 2;
`ifdef IMEM_RESPONDER_ERR_CHECK_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  logic clk = 1'b0, rst_i = 1'b1, req_i = 1'b0, req0 = 1'b0, ready_i = 1'b0;
  logic load_en = 1'b0;
  logic [31:0] addr_i = '0, load_addr = '0, load_data = '0;
  logic ready_o, valid_o, err_o, ready0, valid0, err0;
  logic [31:0] instr_o, instr0;
  logic [31:0] model [DEPTH];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i), .ready_o(ready_o),
    .valid_o(valid_o), .instr_o(instr_o), .err_o(err_o), .ready_i(ready_i),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data));
  imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk_i(clk), .rst_i(rst_i), .req_i(req0), .addr_i(addr_i), .ready_o(ready0),
    .valid_o(valid0), .instr_o(instr0), .err_o(err0), .ready_i(ready_i),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic bit is_err(input logic [31:0] a);
    return ERR && (a[1:0] != 2'b00 || a >= 32'(DEPTH * 4));
  endfunction
  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return is_err(a) ? 32'h0 : model[(a / 4) % DEPTH];
  endfunction
  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1;
    load_addr = a;
    load_data = d;
    step();
    load_en = 1'b0;
    if (!(ERR && a >= 32'(DEPTH * 4))) model[(a / 4) % DEPTH] = d;
  endtask
  task automatic fetch(input string tag, input logic [31:0] a, input int bp);
    logic [31:0] ew;
    bit ee;
    int n;
    ew = exp_word(a);
    ee = is_err(a);
    chk({tag, "_rdy"}, {31'b0, ready_o}, 32'd1);
    req_i = 1'b1;
    addr_i = a;
    ready_i = (bp == 0);
    step();
    req_i = 1'b0;
    addr_i = $urandom();
    n = 1;
    while (!valid_o && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, n, WC + 1);
    chk({tag, "_instr"}, instr_o, ew);
    chk({tag, "_err"}, {31'b0, err_o}, {31'b0, ee});
    for (int i = 0; i < bp; i++) begin
      req_i = $urandom_range(0, 1);
      step();
      chk({tag, "_hold"}, {valid_o, ready_o, instr_o[29:0]}, {1'b1, 1'b0, ew[29:0]});
    end
    req_i = 1'b0;
    ready_i = 1'b1;
    step();
    chk({tag, "_ret"}, {30'b0, ready_o, valid_o}, 32'd2);
    ready_i = 1'b0;
  endtask
  initial begin
    logic [31:0] a, old_w, new_w;
    bit seen;
    rst_i = 1'b0;
    #12;
    chk("reset", {ready_o, valid_o, err_o, 29'b0}, 32'h8000_0000);
    chk("reset_instr", instr_o, 32'h0);
    step();
    rst_i = 1'b1;
    step();
    chk("reset_rel", {30'b0, ready_o, valid_o}, 32'd2);
    for (int i = 0; i < DEPTH; i++) load(32'(i * 4), $urandom());
    load(32'h8, 32'h2001000A);
    fetch("preload", 32'h8, 0);
    chk("preload_val", instr_o, 32'h2001000A);
    fetch("bp", 32'(4 * $urandom_range(0, DEPTH - 1)), 5);
    a = 32'h14;
    old_w = model[5];
    new_w = ~old_w;
    req_i = 1'b1;
    addr_i = a;
    ready_i = 1'b0;
    step();
    req_i = 1'b0;
    for (int i = 0; i < WC - 1; i++) step();
    load(a, new_w);
    chk("coll_valid", {31'b0, valid_o}, 32'd1);
    chk("coll_old", instr_o, old_w);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    fetch("coll_new", a, 0);
    chk("coll_new_val", instr_o, new_w);
    req_i = 1'b1;
    addr_i = 32'h0;
    step();
    req_i = 1'b0;
    rst_i = 1'b0;
    #1;
    chk("rst_wait", {30'b0, ready_o, valid_o}, 32'd2);
    step();
    rst_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen |= valid_o;
    end
    chk("rst_novalid", {31'b0, seen}, 32'd0);
    chk("rst_idle", {31'b0, ready_o}, 32'd1);
    for (int it = 0; it < 30; it++) begin
      for (int k = $urandom_range(0, 2); k > 0; k--)
        load(ERR ? 32'($urandom_range(0, DEPTH * 4 + 16)) & ~32'h3 : $urandom(), $urandom());
      a = ERR ? (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, DEPTH * 4 + 40))
                                               : 32'(4 * $urandom_range(0, DEPTH - 1)))
              : $urandom();
      fetch("rand", a, $urandom_range(0, 3));
    end
`ifdef IMEM_RESPONDER_ERR_CHECK_EN
    fetch("err_misalign", 32'h6, 0);
    chk("err_misalign_flag", {31'b0, err_o}, 32'd1);
    fetch("err_range", 32'(DEPTH * 4), 0);
    chk("err_range_flag", {31'b0, err_o}, 32'd1);
    fetch("err_ok", 32'h4, 0);
    chk("err_ok_flag", {31'b0, err_o}, 32'd0);
`endif
    load(32'h0, 32'h00221820);
    ready_i = 1'b1;
    req0 = 1'b1;
    addr_i = 32'h0;
    step();
    req0 = 1'b0;
    chk("w0_valid", {30'b0, ready0, valid0}, 32'd1);
    chk("w0_instr", instr0, 32'h00221820);
    step();
    chk("w0_ret", {30'b0, ready0, valid0}, 32'd2);
    ready_i = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_responder.md
# imem_responder

Memory-side responder for the CPU's instruction-fetch interface. Accepts one fetch request at a time, waits a configurable number of wait states, then returns the 32-bit instruction word under a valid/ready handshake. It replaces the zero-latency combinational instruction memory when the core is moved to a handshaked, multi-cycle fetch path. It also provides a word-write port so benches and the boot loader can preload program contents.

## Interface
- DEPTH_WORDS, 32, number of 32-bit words stored; power of two, at least 2
- WAIT_CYCLES, 2, wait states between request acceptance and response; 0 to 15
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  reset; asynchronous assert, active-low
- req_i  input  1  fetch request, sampled while ready_o=1
- addr_i  input  32  byte address of the fetch, sampled with req_i
- ready_o  output  1  responder can accept a request (IDLE state)
- valid_o  output  1  response valid; held until ready_i=1
- instr_o  output  32  instruction word; stable while valid_o=1
- err_o  output  1  response is an error; qualified by valid_o
- ready_i  input  1  requester accepts the response
- load_en_i  input  1  write strobe for the preload port
- load_addr_i  input  32  byte address of the preload write
- load_data_i  input  32  preload write data

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- IDLE:
  - ready_o=1.
  - If req_i=1, capture addr_i.
  - Go to WAIT when WAIT_CYCLES>0; load the counter with WAIT_CYCLES-1.
  - Otherwise go directly to RESP.
- WAIT:
  - ready_o=0.
  - The counter decrements each cycle.
  - At counter==0, go to RESP.
- RESP:
  - The array word is read and registered on the transition into RESP.
  - valid_o=1. instr_o and err_o are held stable.
  - If ready_i=1, return to IDLE. No new request is accepted in the same cycle.
- Word index is addr[2 +: log2(DEPTH_WORDS)]. Address bits [1:0] and the bits above the index are ignored, except when error checking is enabled (see Configuration).
- Preload writes:
  - A write occurs whenever load_en_i=1, in any state.
  - The write goes to word index load_addr_i[2 +: log2(DEPTH_WORDS)].
- Read and write to the same word in the same cycle (the cycle entering RESP): the read returns the old contents. The write lands the following cycle.
- The array is not cleared by reset. Contents are retained across rst_i.

## Timing
- Reset values:
  - state=IDLE.
  - ready_o=1, valid_o=0, instr_o=32'h0, err_o=0, counter=0.
- Latency from the accepting edge to valid_o=1 is WAIT_CYCLES+1 cycles.
- Back-to-back throughput is one fetch per WAIT_CYCLES+2 cycles, assuming ready_i is held at 1.
- The requester must keep addr_i stable only during the accepting cycle.
- Reset mid-operation: rst_i low in WAIT or RESP returns the block immediately to IDLE. Any in-flight response is discarded and valid_o drops asynchronously.
- req_i is ignored while ready_o=0. There is no queueing.

## Configuration
- Macro: IMEM_RESPONDER_ERR_CHECK_EN.
- When defined:
  - A request is flagged as an error if addr[1:0]≠0 or addr ≥ DEPTH_WORDS*4.
  - An error request produces err_o=1 and instr_o=32'h0 in RESP.
  - Latency is unchanged.
  - Preload writes to an out-of-range address are dropped.
- When undefined:
  - err_o is tied to 0.
  - All addresses alias modulo DEPTH_WORDS*4, and the low two bits are ignored.

## Structure
- Shared package imem_pkg contains:
  - a state enum {IDLE, WAIT, RESP}, encoded as 2 bits;
  - the constant NOP_WORD=32'h0;
  - the constant WORD_BYTES=4.
- One sub-module, imem_wait_counter: a loadable down-counter that takes load, value and enable inputs and produces a done output.
- The FSM, storage array and output registers are kept in the top-level module.

## Test plan
- Reset: rst_i=0 then 1 -> ready_o=1, valid_o=0, instr_o=0, err_o=0.
- Preload then fetch, WAIT_CYCLES=2:
  - Stimulus: load 32'h2001000A at address 0x8, then request 0x8 with ready_i held at 1.
  - Required response: valid_o rises exactly 3 cycles after the accepting edge, instr_o=32'h2001000A, then ready_o=1 on the next cycle.
- Backpressure:
  - Stimulus: ready_i=0 for 5 cycles during RESP.
  - Required response: valid_o and instr_o are held constant; req_i pulses in that window are ignored; the block returns to IDLE one edge after ready_i=1.
- WAIT_CYCLES=0 build:
  - Stimulus: request address 0x0 containing 32'h00221820.
  - Required response: valid_o=1 one cycle after acceptance.
- Collision and reset:
  - Stimulus: a load to the in-flight word on the RESP-entry edge.
  - Required response: the old word is returned; a subsequent fetch returns the new word.
  - Stimulus: rst_i low during WAIT.
  - Required response: valid_o is never asserted, and the block is in IDLE after release.
- With the error-check macro defined:
  - Request 0x6 -> err_o=1, instr_o=0.
  - Request DEPTH_WORDS*4 -> err_o=1, instr_o=0.
  - Request 0x4 -> err_o=0.
